// File: rtl/alu.sv
// 16-bit signed ALU for the execute stage: one registered result (32 bits) and
// remainder (16 bits) per clock, selected by a 4-bit opcode.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  opcode,
    output logic [31:0] result,
    output logic [15:0] remainder
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;

    // A zero amount yields v >> 16 == 0 on the wrap term, so v passes unchanged.
    function automatic logic [15:0] rol16(input logic [15:0] v, input logic [3:0] n);
        return (v << n) | (v >> (5'd16 - {1'b0, n}));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] v, input logic [3:0] n);
        return (v >> n) | (v << (5'd16 - {1'b0, n}));
    endfunction

    logic signed [31:0] sa_s;
    logic signed [31:0] sb_s;
    logic        [3:0]  amt_s;
    logic        [15:0] quo_s;
    logic        [15:0] sra_s;
    logic        [31:0] res_s;
    logic        [15:0] rem_s;

    assign sa_s  = {{16{a[15]}}, a};
    assign sb_s  = {{16{b[15]}}, b};
    assign amt_s = b[3:0];
    assign sra_s = $signed(a) >>> amt_s;

    // Next-state result/remainder for the current operands and opcode.
    always_comb begin
        res_s = 32'd0;
        rem_s = 16'd0;
        quo_s = 16'd0;
        case (opcode)
            OP_ADD: res_s = sa_s + sb_s;
            OP_SUB: res_s = sa_s - sb_s;
            OP_AND: res_s = {16'd0, a & b};
            OP_OR:  res_s = {16'd0, a | b};
            OP_MUL: res_s = sa_s * sb_s;
            OP_DIV: begin
                // Divide-by-zero and the single overflow case are pinned explicitly.
                if (b == 16'd0) begin
                    res_s = 32'hFFFF_FFFF;
                    rem_s = a;
                end else if ((a == 16'h8000) && (b == 16'hFFFF)) begin
                    res_s = 32'hFFFF_8000;
                    rem_s = 16'd0;
                end else begin
                    quo_s = $signed(a) / $signed(b);
                    rem_s = $signed(a) % $signed(b);
                    res_s = {{16{quo_s[15]}}, quo_s};
                end
            end
            OP_XOR: res_s = {16'd0, a ^ b};
            OP_SRA: res_s = {16'd0, sra_s};
            OP_SLL: res_s = {16'd0, a << amt_s};
            OP_ROL: res_s = {16'd0, rol16(a, amt_s)};
            OP_SRL: res_s = {16'd0, a >> amt_s};
            OP_ROR: res_s = {16'd0, ror16(a, amt_s)};
            default: begin
                res_s = 32'd0;
                rem_s = 16'd0;
            end
        endcase
    end

    // Output registers: cleared asynchronously, loaded every edge otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= 32'd0;
            remainder <= 16'd0;
        end else begin
            result    <= res_s;
            remainder <= rem_s;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: the driver queues expected responses, an
// independent monitor pops one each cycle after an operation is issued.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  opcode;
    logic [31:0] result;
    logic [15:0] remainder;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [15:0] rem;
    } exp_t;

    exp_t exp_q[$];

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .result    (result),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string nm, input logic [31:0] er, input logic [15:0] erm);
        tests_run++;
        if (result !== er || remainder !== erm) begin
            tests_failed++;
            $display("FAIL %s: got result=%h remainder=%h, expected result=%h remainder=%h",
                     nm, result, remainder, er, erm);
        end
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] ia,
                         input logic [15:0] ib, input logic [31:0] er, input logic [15:0] erm);
        @(negedge clk);
        a      = ia;
        b      = ib;
        opcode = op;
        exp_q.push_back('{nm, er, erm});
    endtask

    // Monitor: any operation issued before this edge must be visible just after it.
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_now(e.name, e.res, e.rem);
        end
    end

    initial begin
        rst_n  = 1'b0;
        a      = 16'd5;
        b      = 16'd3;
        opcode = 4'd0;
        #1;
        check_now("reset_async_t0", 32'd0, 16'd0);
        @(negedge clk);
        @(negedge clk);
        check_now("reset_hold", 32'd0, 16'd0);

        // Release: first edge registers 5+3 already on the inputs.
        rst_n = 1'b1;
        exp_q.push_back('{"reset_release_add", 32'd8, 16'd0});

        issue("rol1",  4'd9,  16'h6000, 16'd1, 32'h0000_C000, 16'd0);
        issue("rol2",  4'd9,  16'h6000, 16'd2, 32'h0000_8001, 16'd0);
        issue("rol3",  4'd9,  16'h6000, 16'd3, 32'h0000_0003, 16'd0);
        issue("rol4",  4'd9,  16'h6000, 16'd4, 32'h0000_0006, 16'd0);
        issue("ror1",  4'd11, 16'h6000, 16'd1, 32'h0000_3000, 16'd0);
        issue("ror4",  4'd11, 16'h6000, 16'd4, 32'h0000_0600, 16'd0);
        issue("rol0",  4'd9,  16'hA5C3, 16'h0010, 32'h0000_A5C3, 16'd0);

        issue("mul2x2",  4'd4, 16'd2, 16'd2,  32'd4,  16'd0);
        issue("mul3x8",  4'd4, 16'd3, 16'd8,  32'd24, 16'd0);
        issue("mul0x2",  4'd4, 16'd0, 16'd2,  32'd0,  16'd0);
        issue("mul1x50", 4'd4, 16'd1, 16'd50, 32'd50, 16'd0);
        issue("mul_neg", 4'd4, 16'hFFFD, 16'd8, 32'hFFFF_FFE8, 16'd0);
        issue("mul_min", 4'd4, 16'h8000, 16'h8000, 32'h4000_0000, 16'd0);

        issue("div3_8",   4'd5, 16'd3,  16'd8, 32'd0, 16'd3);
        issue("div20_5",  4'd5, 16'd20, 16'd5, 32'd4, 16'd0);
        issue("div10_2",  4'd5, 16'd10, 16'd2, 32'd5, 16'd0);
        issue("div_neg7", 4'd5, 16'hFFF9, 16'd2, 32'hFFFF_FFFD, 16'hFFFF);
        issue("div_by0",  4'd5, 16'd9,  16'd0, 32'hFFFF_FFFF, 16'd9);
        issue("div_ovf",  4'd5, 16'h8000, 16'hFFFF, 32'hFFFF_8000, 16'd0);

        issue("add3_8",  4'd0, 16'd3, 16'd8, 32'd11, 16'd0);
        issue("sub3_8",  4'd1, 16'd3, 16'd8, 32'hFFFF_FFFB, 16'd0);
        issue("sub_n6500", 4'd1, 16'hE69C, 16'd6500, 32'hFFFF_CD38, 16'd0);
        issue("sub_n20000", 4'd1, 16'hB1E0, 16'h3FFF, 32'hFFFF_71E1, 16'd0);
        issue("add_max", 4'd0, 16'h7FFF, 16'h7FFF, 32'h0000_FFFE, 16'd0);

        issue("and20_5", 4'd2, 16'd20, 16'd5, 32'd4,  16'd0);
        issue("or20_5",  4'd3, 16'd20, 16'd5, 32'd21, 16'd0);
        issue("or3_8",   4'd3, 16'd3,  16'd8, 32'd11, 16'd0);
        issue("xor",     4'd6, 16'hF0F0, 16'hFF00, 32'h0000_0FF0, 16'd0);
        issue("rsvd13",  4'd13, 16'd20, 16'd5, 32'd0, 16'd0);
        issue("rsvd15",  4'd15, 16'hFFFF, 16'hFFFF, 32'd0, 16'd0);

        issue("sra",     4'd7,  16'h8000, 16'd4, 32'h0000_F800, 16'd0);
        issue("sll_hib", 4'd8,  16'h0001, 16'hFFFF, 32'h0000_8000, 16'd0);
        issue("srl",     4'd10, 16'h8000, 16'd4, 32'h0000_0800, 16'd0);
        issue("sll0",    4'd8,  16'h1234, 16'h0000, 32'h0000_1234, 16'd0);

        // Mid-stream reset: the operation presented before the edge is discarded.
        @(negedge clk);
        a      = 16'd100;
        b      = 16'd1;
        opcode = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check_now("reset_async_mid", 32'd0, 16'd0);
        @(posedge clk);
        #1;
        check_now("reset_discard", 32'd0, 16'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        a      = 16'd7;
        b      = 16'd2;
        opcode = 4'd1;
        exp_q.push_back('{"after_reset_sub", 32'd5, 16'd0});
        issue("after_reset_mul", 4'd4, 16'd7, 16'd3, 32'd21, 16'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d responses never checked, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
